control_unit: RTL and testbench

//  Hardwired Moore control sequencer that produces the datapath control strobes: register in/out

---
 rtl/control_unit_pkg.sv | 84 ++++++++
 rtl/control_unit_decode.sv | 109 ++++++++++
 rtl/control_unit.sv | 134 +++++++++++++
 tb/tb_control_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the control sequencer: state encodings, opcode
// values, instruction classes and the packed strobe vector that the decode
// block produces for the top level.
package control_unit_pkg;

   // Sequencer states. Nine legal codes in a 4-bit register; every other
   // code is treated as corruption and steers back to S_RST.
   typedef enum logic [3:0] {
      S_RST  = 4'd0,
      T0     = 4'd1,
      T1     = 4'd2,
      T2     = 4'd3,
      T3     = 4'd4,
      T4     = 4'd5,
      T5     = 4'd6,
      T6     = 4'd7,
      S_HALT = 4'd8
   } state_t;

   // Opcodes (IR[31:27])
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // Instruction classes; each class shares one execute sequence.
   typedef enum logic [2:0] {
      CLS_NONE   = 3'd0,   // nop and unlisted opcodes: fetch only
      CLS_ALU3   = 3'd1,   // Ra <= Rb op Rc
      CLS_MULDIV = 3'd2,   // HI:LO <= Ra op Rb
      CLS_UNARY  = 3'd3,   // Ra <= op Rb
      CLS_HALT   = 3'd4
   } op_class_t;

   // Strobe vector driven by the decode block.
   typedef struct packed {
      logic       pc_out;
      logic       pc_in;
      logic       inc_pc;
      logic       ir_in;
      logic       mar_in;
      logic       mdr_in;
      logic       mdr_out;
      logic       read;
      logic       y_in;
      logic       z_in;
      logic       zlow_out;
      logic       zhigh_out;
      logic       lo_in;
      logic       hi_in;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       r_in;
      logic       r_out;
      logic [4:0] alu;
      logic       run;
   } ctrl_t;

   function automatic op_class_t op_class(input logic [4:0] op);
      op_class_t cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  cls = CLS_ALU3;
         OP_MUL, OP_DIV:                   cls = CLS_MULDIV;
         OP_NEG, OP_NOT:                   cls = CLS_UNARY;
         OP_HALT:                          cls = CLS_HALT;
         default:                          cls = CLS_NONE;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational decode of sequencer state + opcode into datapath strobes.
// Ports:
//   state   in  state_t  registered sequencer state
//   opcode  in  OPW      IR[31:27]; only consulted from T3 onward
//   ctrl    out ctrl_t   strobe vector, ALU select and run flag
// Each state asserts at most one bus driver (*_out or R_out).
module control_unit_decode
   import control_unit_pkg::*;
#(
   parameter int OPW = 5
) (
   input  state_t         state,
   input  logic [OPW-1:0] opcode,
   output ctrl_t          ctrl
);

   op_class_t cls;
   assign cls = op_class(opcode);

   always_comb begin
      ctrl = '0;
      case (state)
         T0: begin
            ctrl.pc_out = 1'b1;
            ctrl.mar_in = 1'b1;
            ctrl.inc_pc = 1'b1;
            ctrl.z_in   = 1'b1;
         end
         T1: begin
            // Held unchanged through a memory stall; reloading PC from Z
            // is harmless because Z is not re-captured here.
            ctrl.zlow_out = 1'b1;
            ctrl.pc_in    = 1'b1;
            ctrl.read     = 1'b1;
            ctrl.mdr_in   = 1'b1;
         end
         T2: begin
            ctrl.mdr_out = 1'b1;
            ctrl.ir_in   = 1'b1;
         end
         T3: begin
            case (cls)
               CLS_ALU3: begin
                  ctrl.grb   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.y_in  = 1'b1;
               end
               CLS_MULDIV: begin
                  ctrl.gra   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.y_in  = 1'b1;
               end
               CLS_UNARY: begin
                  ctrl.grb   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.z_in  = 1'b1;
                  ctrl.alu   = opcode;
               end
               default: ;
            endcase
         end
         T4: begin
            case (cls)
               CLS_ALU3: begin
                  ctrl.grc   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.z_in  = 1'b1;
                  ctrl.alu   = opcode;
               end
               CLS_MULDIV: begin
                  ctrl.grb   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.z_in  = 1'b1;
                  ctrl.alu   = opcode;
               end
               CLS_UNARY: begin
                  ctrl.zlow_out = 1'b1;
                  ctrl.gra      = 1'b1;
                  ctrl.r_in     = 1'b1;
               end
               default: ;
            endcase
         end
         T5: begin
            case (cls)
               CLS_ALU3: begin
                  ctrl.zlow_out = 1'b1;
                  ctrl.gra      = 1'b1;
                  ctrl.r_in     = 1'b1;
               end
               CLS_MULDIV: begin
                  ctrl.zlow_out = 1'b1;
                  ctrl.lo_in    = 1'b1;
               end
               default: ;
            endcase
         end
         T6: begin
            if (cls == CLS_MULDIV) begin
               ctrl.zhigh_out = 1'b1;
               ctrl.hi_in     = 1'b1;
            end
         end
         default: ;   // S_RST, S_HALT and illegal codes drive nothing
      endcase
      ctrl.run = (state inside {T0, T1, T2, T3, T4, T5, T6});
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the datapath: fetch (T0..T2) plus
// execute sequences for 3-operand ALU, mul/div, neg/not, nop and halt.
// Ports:
//   clk             in   system clock
//   clr             in   synchronous active-low reset
//   IR_Data         in   instruction register; opcode in [31:27]
//   mem_ready       in   memory data valid, releases the T1 stall
//   PC_out..R_out   out  datapath strobes (pure decode of state + opcode)
//   alu_instruction out  ALU op select, nonzero only in the Z_in cycle of an ALU op
//   run             out  high in T0..T6
module control_unit
   import control_unit_pkg::*;
#(
   parameter int OPW           = 5,
   parameter int RESET_PC_HOLD = 1
) (
   input  logic           clk,
   input  logic           clr,
   input  logic [31:0]    IR_Data,
   input  logic           mem_ready,
   output logic           PC_out,
   output logic           PC_in,
   output logic           IncPC,
   output logic           IR_in,
   output logic           MAR_in,
   output logic           MDR_in,
   output logic           MDR_out,
   output logic           Read,
   output logic           Y_in,
   output logic           Z_in,
   output logic           Zlow_out,
   output logic           Zhigh_out,
   output logic           LO_in,
   output logic           HI_in,
   output logic           Gra,
   output logic           Grb,
   output logic           Grc,
   output logic           R_in,
   output logic           R_out,
   output logic [OPW-1:0] alu_instruction,
   output logic           run
);

   localparam int HOLD_W = (RESET_PC_HOLD < 1) ? 1 : $clog2(RESET_PC_HOLD + 1);

   state_t            state_reg, state_next;
   logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic [OPW-1:0]    opcode;
   ctrl_t             ctrl;
   logic              unused_ir;

   assign opcode    = IR_Data[31 -: OPW];
   assign unused_ir = ^IR_Data[31-OPW:0];

   // State register
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_reg    <= S_RST;
         hold_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         hold_cnt_reg <= hold_cnt_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next    = S_RST;
      hold_cnt_next = '0;
      case (state_reg)
         S_RST: begin
            // Count clr-released cycles spent here before starting fetch.
            if (32'(hold_cnt_reg) + 1 >= RESET_PC_HOLD) begin
               state_next = T0;
            end else begin
               state_next    = S_RST;
               hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
            end
         end
         T0: state_next = T1;
         T1: state_next = mem_ready ? T2 : T1;
         T2: begin
            case (op_class(opcode))
               CLS_HALT: state_next = S_HALT;
               CLS_NONE: state_next = T0;
               default:  state_next = T3;
            endcase
         end
         T3: state_next = (op_class(opcode) == CLS_NONE) ? T0 : T4;
         T4: begin
            case (op_class(opcode))
               CLS_ALU3, CLS_MULDIV: state_next = T5;
               default:              state_next = T0;
            endcase
         end
         T5: state_next = (op_class(opcode) == CLS_MULDIV) ? T6 : T0;
         T6: state_next = T0;
         S_HALT: state_next = S_HALT;
         default: state_next = S_RST;   // illegal encoding recovers via reset state
      endcase
   end

   // Output decode
   control_unit_decode #(
      .OPW (OPW)
   ) u_decode (
      .state  (state_reg),
      .opcode (opcode),
      .ctrl   (ctrl)
   );

   assign PC_out          = ctrl.pc_out;
   assign PC_in           = ctrl.pc_in;
   assign IncPC           = ctrl.inc_pc;
   assign IR_in           = ctrl.ir_in;
   assign MAR_in          = ctrl.mar_in;
   assign MDR_in          = ctrl.mdr_in;
   assign MDR_out         = ctrl.mdr_out;
   assign Read            = ctrl.read;
   assign Y_in            = ctrl.y_in;
   assign Z_in            = ctrl.z_in;
   assign Zlow_out        = ctrl.zlow_out;
   assign Zhigh_out       = ctrl.zhigh_out;
   assign LO_in           = ctrl.lo_in;
   assign HI_in           = ctrl.hi_in;
   assign Gra             = ctrl.gra;
   assign Grb             = ctrl.grb;
   assign Grc             = ctrl.grc;
   assign R_in            = ctrl.r_in;
   assign R_out           = ctrl.r_out;
   assign alu_instruction = ctrl.alu;
   assign run             = ctrl.run;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] IR_Data;
   logic        mem_ready;
   logic PC_out, PC_in, IncPC, IR_in, MAR_in, MDR_in, MDR_out, Read;
   logic Y_in, Z_in, Zlow_out, Zhigh_out, LO_in, HI_in;
   logic Gra, Grb, Grc, R_in, R_out;
   logic [4:0] alu_instruction;
   logic run;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   control_unit dut (
      .clk(clk), .clr(clr), .IR_Data(IR_Data), .mem_ready(mem_ready),
      .PC_out(PC_out), .PC_in(PC_in), .IncPC(IncPC), .IR_in(IR_in),
      .MAR_in(MAR_in), .MDR_in(MDR_in), .MDR_out(MDR_out), .Read(Read),
      .Y_in(Y_in), .Z_in(Z_in), .Zlow_out(Zlow_out), .Zhigh_out(Zhigh_out),
      .LO_in(LO_in), .HI_in(HI_in), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .R_in(R_in), .R_out(R_out), .alu_instruction(alu_instruction), .run(run)
   );

   // Observed strobe vector, one bit per output
   logic [18:0] obs;
   assign obs = {PC_out, PC_in, IncPC, IR_in, MAR_in, MDR_in, MDR_out, Read,
                 Y_in, Z_in, Zlow_out, Zhigh_out, LO_in, HI_in,
                 Gra, Grb, Grc, R_in, R_out};

   logic [2:0] n_drv;
   assign n_drv = 3'(PC_out) + 3'(MDR_out) + 3'(Zlow_out) + 3'(Zhigh_out) + 3'(R_out);

   localparam logic [18:0] B_PC_OUT    = 19'h1 << 18;
   localparam logic [18:0] B_PC_IN     = 19'h1 << 17;
   localparam logic [18:0] B_INC_PC    = 19'h1 << 16;
   localparam logic [18:0] B_IR_IN     = 19'h1 << 15;
   localparam logic [18:0] B_MAR_IN    = 19'h1 << 14;
   localparam logic [18:0] B_MDR_IN    = 19'h1 << 13;
   localparam logic [18:0] B_MDR_OUT   = 19'h1 << 12;
   localparam logic [18:0] B_READ      = 19'h1 << 11;
   localparam logic [18:0] B_Y_IN      = 19'h1 << 10;
   localparam logic [18:0] B_Z_IN      = 19'h1 << 9;
   localparam logic [18:0] B_ZLOW_OUT  = 19'h1 << 8;
   localparam logic [18:0] B_ZHIGH_OUT = 19'h1 << 7;
   localparam logic [18:0] B_LO_IN     = 19'h1 << 6;
   localparam logic [18:0] B_HI_IN     = 19'h1 << 5;
   localparam logic [18:0] B_GRA       = 19'h1 << 4;
   localparam logic [18:0] B_GRB       = 19'h1 << 3;
   localparam logic [18:0] B_GRC       = 19'h1 << 2;
   localparam logic [18:0] B_R_IN      = 19'h1 << 1;
   localparam logic [18:0] B_R_OUT     = 19'h1;

   localparam logic [18:0] V_T0 = B_PC_OUT | B_MAR_IN | B_INC_PC | B_Z_IN;
   localparam logic [18:0] V_T1 = B_ZLOW_OUT | B_PC_IN | B_READ | B_MDR_IN;
   localparam logic [18:0] V_T2 = B_MDR_OUT | B_IR_IN;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b0; IR_Data = 32'h0; mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_vec++;
         if (obs !== 19'h0 || alu_instruction !== 5'h0 || run !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold[%0d]: strobes=%h alu=%h run=%b, want 0/0/0", i, obs, alu_instruction, run);
         end
      end
      clr = 1'b1;
      #1;
      n_vec++;
      if (obs !== 19'h0 || run !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: strobes=%h run=%b, want 0/0", obs, run);
      end
      step();
      n_vec++;
      if (obs !== V_T0 || alu_instruction !== 5'h0 || run !== 1'b1) begin
         n_err++;
         $display("FAIL reset_first_t0: strobes=%h alu=%h run=%b, want %h/0/1", obs, alu_instruction, run, V_T0);
      end
      $display("test_reset done");
   endtask

   // add R0,R4,R5: T0..T5 then back to T0 on the seventh observed cycle
   task automatic test_add();
      logic [18:0] es [7];
      logic [4:0]  ea [7];
      es = '{V_T0, V_T1, V_T2, B_GRB | B_R_OUT | B_Y_IN, B_GRC | B_R_OUT | B_Z_IN,
             B_ZLOW_OUT | B_GRA | B_R_IN, V_T0};
      ea = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0};
      IR_Data = 32'h18228000;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) step();
         n_vec++;
         if (obs !== es[i] || alu_instruction !== ea[i] || run !== 1'b1) begin
            n_err++;
            $display("FAIL add_cycle[%0d]: strobes=%h alu=%h run=%b, want %h/%h/1", i, obs, alu_instruction, run, es[i], ea[i]);
         end
      end
      $display("test_add done");
   endtask

   // nop fetch with mem_ready low for three T1 edges
   task automatic test_stall();
      IR_Data   = 32'hD0000000;
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_vec++;
         if (obs !== V_T1 || run !== 1'b1) begin
            n_err++;
            $display("FAIL stall_t1[%0d]: strobes=%h run=%b, want %h/1", i, obs, run, V_T1);
         end
      end
      mem_ready = 1'b1;
      step();
      n_vec++;
      if (obs !== V_T2) begin
         n_err++;
         $display("FAIL stall_release_t2: strobes=%h, want %h", obs, V_T2);
      end
      step();
      n_vec++;
      if (obs !== V_T0) begin
         n_err++;
         $display("FAIL nop_back_t0: strobes=%h, want %h", obs, V_T0);
      end
      $display("test_stall done");
   endtask

   // mul: 7-cycle instruction, LO then HI writeback
   task automatic test_mul();
      logic [18:0] es [8];
      logic [4:0]  ea [8];
      es = '{V_T0, V_T1, V_T2, B_GRA | B_R_OUT | B_Y_IN, B_GRB | B_R_OUT | B_Z_IN,
             B_ZLOW_OUT | B_LO_IN, B_ZHIGH_OUT | B_HI_IN, V_T0};
      ea = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b01111, 5'd0, 5'd0, 5'd0};
      IR_Data = 32'h78000000;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) step();
         n_vec++;
         if (obs !== es[i] || alu_instruction !== ea[i]) begin
            n_err++;
            $display("FAIL mul_cycle[%0d]: strobes=%h alu=%h, want %h/%h", i, obs, alu_instruction, es[i], ea[i]);
         end
      end
      $display("test_mul done");
   endtask

   // neg: 5-cycle instruction, ALU select in T3
   task automatic test_neg();
      logic [18:0] es [6];
      logic [4:0]  ea [6];
      es = '{V_T0, V_T1, V_T2, B_GRB | B_R_OUT | B_Z_IN, B_ZLOW_OUT | B_GRA | B_R_IN, V_T0};
      ea = '{5'd0, 5'd0, 5'd0, 5'b10001, 5'd0, 5'd0};
      IR_Data = 32'h88000000;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         n_vec++;
         if (obs !== es[i] || alu_instruction !== ea[i]) begin
            n_err++;
            $display("FAIL neg_cycle[%0d]: strobes=%h alu=%h, want %h/%h", i, obs, alu_instruction, es[i], ea[i]);
         end
      end
      $display("test_neg done");
   endtask

   task automatic test_halt();
      IR_Data = 32'hD8000000;
      step();
      n_vec++;
      if (obs !== V_T1) begin
         n_err++;
         $display("FAIL halt_t1: strobes=%h, want %h", obs, V_T1);
      end
      step();
      n_vec++;
      if (obs !== V_T2) begin
         n_err++;
         $display("FAIL halt_t2: strobes=%h, want %h", obs, V_T2);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         n_vec++;
         if (obs !== 19'h0 || alu_instruction !== 5'h0 || run !== 1'b0) begin
            n_err++;
            $display("FAIL halt_idle[%0d]: strobes=%h alu=%h run=%b, want 0/0/0", i, obs, alu_instruction, run);
         end
      end
      IR_Data = 32'h0;
      clr = 1'b0;
      step();
      clr = 1'b1;
      #1;
      n_vec++;
      if (obs !== 19'h0 || run !== 1'b0) begin
         n_err++;
         $display("FAIL halt_to_rst: strobes=%h run=%b, want 0/0", obs, run);
      end
      step();
      n_vec++;
      if (obs !== V_T0 || run !== 1'b1) begin
         n_err++;
         $display("FAIL halt_restart_t0: strobes=%h run=%b, want %h/1", obs, run, V_T0);
      end
      $display("test_halt done");
   endtask

   // reset asserted in T4 of add; drivers checked every cycle
   task automatic test_reset_mid();
      IR_Data = 32'h18228000;
      for (int i = 1; i <= 4; i++) begin
         step();
         n_vec++;
         if (n_drv > 3'd1) begin
            n_err++;
            $display("FAIL one_driver_fetch[%0d]: drivers=%0d, want <=1", i, n_drv);
         end
      end
      n_vec++;
      if (obs !== (B_GRC | B_R_OUT | B_Z_IN) || alu_instruction !== 5'b00011) begin
         n_err++;
         $display("FAIL midreset_t4: strobes=%h alu=%h, want %h/03", obs, alu_instruction, B_GRC | B_R_OUT | B_Z_IN);
      end
      clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_vec++;
         if (obs !== 19'h0 || Z_in !== 1'b0 || R_in !== 1'b0 || n_drv > 3'd1 || run !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_rst[%0d]: strobes=%h Z_in=%b R_in=%b drivers=%0d run=%b, want all 0",
                     i, obs, Z_in, R_in, n_drv, run);
         end
      end
      clr = 1'b1;
      IR_Data = 32'h0;
      step();
      n_vec++;
      if (obs !== V_T0) begin
         n_err++;
         $display("FAIL midreset_restart_t0: strobes=%h, want %h", obs, V_T0);
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_add();
      test_stall();
      test_mul();
      test_neg();
      test_halt();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
